piso_serializer: RTL and testbench

//  Parallel-in/serial-out transmitter. Accepts a DATA_W-bit word over a valid/ready

---
 rtl/piso_serializer.sv | 169 ++++++++++++++++
 tb/tb_piso_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// A DATA_W-bit word is taken over a valid/ready handshake and then driven out
// one bit per clock on sout, qualified by sout_valid. The last bit of a frame
// is flagged by a one-cycle done pulse.
// Optional feature: define PARITY_EN to append one even-parity bit (^word)
// after the data bits. With the macro undefined the PARITY state is not built.
module piso_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  // The counter holds the index of the bit currently on sout.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
`ifndef PARITY_EN
  localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(DATA_W - 2);
`endif

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sout_q, sout_d;
  logic                sout_valid_q, sout_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
`ifdef PARITY_EN
  logic                parity_q, parity_d;
`endif

  // Bit that leaves the word first in the configured order.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) begin
      return w[DATA_W-1];
    end else begin
      return w[0];
    end
  endfunction

  // Drop the head bit and fill the vacated position with zero.
  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) begin
      return {w[DATA_W-2:0], 1'b0};
    end else begin
      return {1'b0, w[DATA_W-1:1]};
    end
  endfunction

  // Next-state, datapath and registered-output logic for the transmit FSM.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    sout_d       = 1'b0;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;
`ifdef PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (din_valid && ready_q) begin
          // The head bit goes straight to sout; shreg keeps the remainder.
          state_d      = ST_SHIFT;
          shreg_d      = shift_word(din);
          cnt_d        = '0;
          sout_d       = head_bit(din);
          sout_valid_d = 1'b1;
`ifdef PARITY_EN
          parity_d     = ^din;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_IDX) begin
`ifdef PARITY_EN
          state_d      = ST_PARITY;
          sout_d       = parity_q;
          sout_valid_d = 1'b1;
          done_d       = 1'b1;
`else
          state_d      = ST_IDLE;
`endif
          shreg_d      = '0;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          sout_d       = head_bit(shreg_q);
          shreg_d      = shift_word(shreg_q);
          sout_valid_d = 1'b1;
`ifndef PARITY_EN
          done_d       = (cnt_q == PENULT_IDX);
`endif
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Ready and busy are decoded from the next state so they line up with it.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
`ifdef PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
`ifdef PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign din_ready  = ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives an MSB-first and an LSB-first instance (DATA_W=8)
// from the same stimulus and compares every output, every cycle, against a
// frame-level reference model.
module tb_piso_serializer;

`ifdef PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;

  logic m_ready, m_sout, m_valid, m_busy, m_done;
  logic l_ready, l_sout, l_valid, l_busy, l_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the frame in flight and the position being sent.
  logic [FRAME_LEN-1:0] fr_msb, fr_lsb;
  int   pos = 0;
  logic exp_ready = 1'b0, exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  logic exp_sout_m = 1'b0, exp_sout_l = 1'b0;
  logic accepted = 1'b0;

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(m_ready), .sout(m_sout), .sout_valid(m_valid),
    .busy(m_busy), .done(m_done)
  );

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(l_ready), .sout(l_sout), .sout_valid(l_valid),
    .busy(l_busy), .done(l_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build the serial frames of a word in both bit orders.
  task automatic build_frames(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      fr_msb[i] = w[7-i];
      fr_lsb[i] = w[i];
    end
`ifdef PARITY_EN
    fr_msb[8] = ^w;
    fr_lsb[8] = ^w;
`endif
  endtask

  task automatic model_idle();
    exp_valid  = 1'b0;
    exp_busy   = 1'b0;
    exp_done   = 1'b0;
    exp_sout_m = 1'b0;
    exp_sout_l = 1'b0;
  endtask

  // One clock: advance the model at the rising edge, check outputs at the falling edge.
  task automatic step();
    @(posedge clk);
    accepted = 1'b0;
    if (reset) begin
      model_idle();
      exp_ready = 1'b0;
      pos = 0;
    end else if (exp_ready && din_valid) begin
      accepted = 1'b1;
      build_frames(din);
      pos = 0;
      exp_sout_m = fr_msb[0];
      exp_sout_l = fr_lsb[0];
      exp_valid  = 1'b1;
      exp_busy   = 1'b1;
      exp_done   = (FRAME_LEN == 1);
      exp_ready  = 1'b0;
    end else if (exp_valid && pos < FRAME_LEN - 1) begin
      pos++;
      exp_sout_m = fr_msb[pos];
      exp_sout_l = fr_lsb[pos];
      exp_done   = (pos == FRAME_LEN - 1);
    end else begin
      model_idle();
      exp_ready = 1'b1;
    end
    @(negedge clk);
    chk("m_ready", m_ready, exp_ready);
    chk("m_valid", m_valid, exp_valid);
    chk("m_sout",  m_sout,  exp_sout_m);
    chk("m_busy",  m_busy,  exp_busy);
    chk("m_done",  m_done,  exp_done);
    chk("l_ready", l_ready, exp_ready);
    chk("l_valid", l_valid, exp_valid);
    chk("l_sout",  l_sout,  exp_sout_l);
    chk("l_busy",  l_busy,  exp_busy);
    chk("l_done",  l_done,  exp_done);
  endtask

  // Present a word and hold it until the handshake completes (bounded).
  task automatic send(input logic [7:0] w, output int cycles);
    din = w;
    din_valid = 1'b1;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!accepted && cycles < 40);
    chk("accept_timeout", {31'd0, accepted}, 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int         gap;
  logic [7:0] obs_word;

  initial begin
    // Reset held three cycles with a pending word: nothing may be accepted.
    reset = 1'b1;
    din = 8'hA5;
    din_valid = 1'b1;
    run(3);
    chk("reset_ready", {31'd0, m_ready}, 32'd0);
    reset = 1'b0;
    din_valid = 1'b0;
    step();
    chk("ready_after_reset", {31'd0, m_ready}, 32'd1);

    // 8'hA5 MSB-first: collect the bits directly as well as via the model.
    send(8'hA5, gap);
    din_valid = 1'b0;
    obs_word = {7'd0, m_sout};
    for (int i = 1; i < 8; i++) begin
      step();
      obs_word = {obs_word[6:0], m_sout};
    end
    chk("a5_msb_word", {24'd0, obs_word}, 32'h0000_00A5);
    run(FRAME_LEN - 8 + 2);

    // 8'h01: LSB-first sends a 1 first, MSB-first a 1 last.
    send(8'h01, gap);
    din_valid = 1'b0;
    chk("lsb_first_bit", {31'd0, l_sout}, 32'd1);
    run(FRAME_LEN + 1);

    // Back-to-back words with din_valid held: spacing is one frame plus one idle cycle.
    send(8'hFF, gap);
    send(8'h00, gap);
    chk("b2b_spacing", gap, FRAME_LEN + 1);
    din_valid = 1'b0;
    run(FRAME_LEN + 1);

`ifdef PARITY_EN
    // Parity frames: 8'h07 has odd weight, 8'h03 even.
    send(8'h07, gap);
    din_valid = 1'b0;
    run(8);
    chk("parity_07", {30'd0, m_sout, m_done}, 32'd3);
    run(1);
    send(8'h03, gap);
    din_valid = 1'b0;
    run(8);
    chk("parity_03", {30'd0, m_sout, m_done}, 32'd1);
    run(1);
`endif

    // Reset in cycle N+4 of a word, then a fresh word 8'h3C.
    send(8'hC3, gap);
    din_valid = 1'b0;
    run(3);
    reset = 1'b1;
    step();
    chk("abort_busy", {31'd0, m_busy}, 32'd0);
    reset = 1'b0;
    run(FRAME_LEN + 1);
    send(8'h3C, gap);
    din_valid = 1'b0;
    run(FRAME_LEN + 1);

    // Random words with random idle gaps and din noise while busy.
    for (int k = 0; k < 24; k++) begin
      send(8'($urandom), gap);
      din_valid = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      run(FRAME_LEN - 1);
      din_valid = 1'b0;
      run(int'($urandom_range(0, 3)));
    end
    run(FRAME_LEN + 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
